// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: the frame FSM states and the
// number of data bits carried by one frame.
package uart_rx_pkg;

   localparam int FRAME_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to 1
// so an idle-high serial line never looks like a start bit coming out of reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value of its neighbour, which keeps the two stages distinct.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples the synchronized line at mid-bit and presents a
// complete byte on data_out together with a single-cycle rd_done pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int SEQ       = 100_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_en,
   input  logic       RX,
   output logic [7:0] data_out,
   output logic       rd_done
);

   localparam int CLKS_PER_BIT = SEQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = $clog2(FRAME_BITS);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);

   logic                  rx_s;
   rx_state_t             state_q,  state_n;
   logic [CNT_W-1:0]      cnt_q,    cnt_n;
   logic [IDX_W-1:0]      idx_q,    idx_n;
   logic [FRAME_BITS-1:0] shift_q,  shift_n;
   logic [7:0]            data_q,   data_n;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (RX),
      .q     (rx_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         shift_q <= shift_n;
         data_q  <= data_n;
      end
   end

   // NOTE: every signal written here is given a default first, so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      shift_n = shift_q;
      data_n  = data_q;

      unique case (state_q)
         IDLE: begin
            if (rd_en && !rx_s) begin
               cnt_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift_q[FRAME_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  idx_n   = '0;
                  state_n = STOP;
               end else begin
                  idx_n = idx_q + 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n = '0;
               // A low stop bit is a framing error: the byte is dropped.
               if (rx_s) begin
                  data_n  = shift_q;
                  state_n = DONE;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign data_out = data_q;
   assign rd_done  = (state_q == DONE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period (16 clocks per bit) so a
// whole frame fits in 160 cycles; expected bytes are written out by hand.
module tb_uart_rx;

   localparam int CLKS = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd_en;
   logic       RX;
   logic [7:0] data_out;
   logic       rd_done;

   int total = 0;
   int bad   = 0;

   int         cycle     = 0;
   int         start_cyc = 0;
   int         pulse_cyc = 0;
   int         wide_cnt  = 0;
   logic       done_prev = 1'b0;
   logic [7:0] rx_q[$];

   uart_rx #(
      .SEQ       (1600),
      .BAUD_RATE (100)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .RX       (RX),
      .data_out (data_out),
      .rd_done  (rd_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Record every pulse and the byte visible with it; flag pulses wider than one clock.
   always @(negedge clk) begin
      if (rd_done === 1'b1) begin
         rx_q.push_back(data_out);
         pulse_cyc = cycle;
         if (done_prev === 1'b1) wide_cnt++;
      end
      done_prev = rd_done;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start, 8 data bits LSB first, then the given stop bit. When
   // drop_after >= 0, rd_en is lowered once that data bit has been sent.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int drop_after);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         RX = bits[i];
         if (i == 0) start_cyc = cycle;
         repeat (CLKS - 1) @(negedge clk);
         if (drop_after >= 0 && i == drop_after + 1) rd_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rd_en = 1'b0;
      RX    = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      total++;
      if (data_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_data: got %h want %h", data_out, 8'h00);
      end
      total++;
      if (rd_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_done: got %b want %b", rd_done, 1'b0);
      end
   endtask

   task automatic test_single();
      int lat;
      rd_en = 1'b1;
      rx_q.delete();
      wide_cnt = 0;
      send_frame(8'hA5, 1'b1, -1);
      idle(4);
      total++;
      if (rx_q.size() !== 1) begin
         bad++;
         $display("FAIL single_count: got %0d want %0d", rx_q.size(), 1);
      end else begin
         total++;
         if (rx_q[0] !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got %h want %h", rx_q[0], 8'hA5);
         end
      end
      // 9.5 bits of 16 clocks is 152, plus synchronizer and FSM registration.
      lat = pulse_cyc - start_cyc;
      total++;
      if (lat < 150 || lat > 160) begin
         bad++;
         $display("FAIL single_latency: got %0d want 150..160", lat);
      end
      total++;
      if (wide_cnt !== 0) begin
         bad++;
         $display("FAIL single_width: got %0d wide pulses want 0", wide_cnt);
      end
      total++;
      if (data_out !== 8'hA5) begin
         bad++;
         $display("FAIL single_hold: got %h want %h", data_out, 8'hA5);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b[5];
      exp_b = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A};
      rx_q.delete();
      wide_cnt = 0;
      for (int i = 0; i < 5; i++) send_frame(exp_b[i], 1'b1, -1);
      idle(4);
      total++;
      if (rx_q.size() !== 5) begin
         bad++;
         $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), 5);
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (rx_q[i] !== exp_b[i]) begin
               bad++;
               $display("FAIL b2b_data%0d: got %h want %h", i, rx_q[i], exp_b[i]);
            end
         end
      end
      total++;
      if (wide_cnt !== 0) begin
         bad++;
         $display("FAIL b2b_width: got %0d wide pulses want 0", wide_cnt);
      end
   endtask

   task automatic test_glitch();
      rx_q.delete();
      @(negedge clk);
      RX = 1'b0;
      idle(5);
      RX = 1'b1;
      idle(3 * CLKS);
      total++;
      if (rx_q.size() !== 0) begin
         bad++;
         $display("FAIL glitch_count: got %0d want %0d", rx_q.size(), 0);
      end
      total++;
      if (data_out !== 8'h5A) begin
         bad++;
         $display("FAIL glitch_data: got %h want %h", data_out, 8'h5A);
      end
   endtask

   task automatic test_framing();
      rx_q.delete();
      send_frame(8'h55, 1'b0, -1);
      @(negedge clk);
      RX = 1'b1;
      idle(3 * CLKS);
      total++;
      if (rx_q.size() !== 0) begin
         bad++;
         $display("FAIL frame_err_count: got %0d want %0d", rx_q.size(), 0);
      end
      total++;
      if (data_out !== 8'h5A) begin
         bad++;
         $display("FAIL frame_err_data: got %h want %h", data_out, 8'h5A);
      end
      send_frame(8'h12, 1'b1, -1);
      idle(4);
      total++;
      if (rx_q.size() !== 1) begin
         bad++;
         $display("FAIL frame_next_count: got %0d want %0d", rx_q.size(), 1);
      end
      total++;
      if (data_out !== 8'h12) begin
         bad++;
         $display("FAIL frame_next_data: got %h want %h", data_out, 8'h12);
      end
   endtask

   task automatic test_rd_en();
      rx_q.delete();
      rd_en = 1'b0;
      send_frame(8'h77, 1'b1, -1);
      idle(2 * CLKS);
      total++;
      if (rx_q.size() !== 0) begin
         bad++;
         $display("FAIL en_off_count: got %0d want %0d", rx_q.size(), 0);
      end
      total++;
      if (data_out !== 8'h12) begin
         bad++;
         $display("FAIL en_off_data: got %h want %h", data_out, 8'h12);
      end
      rd_en = 1'b1;
      send_frame(8'h77, 1'b1, 3);
      idle(4);
      total++;
      if (rx_q.size() !== 1) begin
         bad++;
         $display("FAIL en_drop_count: got %0d want %0d", rx_q.size(), 1);
      end
      total++;
      if (data_out !== 8'h77) begin
         bad++;
         $display("FAIL en_drop_data: got %h want %h", data_out, 8'h77);
      end
      rd_en = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      rx_q.delete();
      // Start bit and a low bit 0, then the line stays high so nothing restarts.
      @(negedge clk);
      RX = 1'b0;
      idle(2 * CLKS);
      RX = 1'b1;
      idle(CLKS + 4);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (data_out !== 8'h00) begin
         bad++;
         $display("FAIL midrst_data: got %h want %h", data_out, 8'h00);
      end
      total++;
      if (rd_done !== 1'b0) begin
         bad++;
         $display("FAIL midrst_done: got %b want %b", rd_done, 1'b0);
      end
      idle(8 * CLKS);
      total++;
      if (rx_q.size() !== 0) begin
         bad++;
         $display("FAIL midrst_count: got %0d want %0d", rx_q.size(), 0);
      end
      send_frame(8'hC3, 1'b1, -1);
      idle(4);
      total++;
      if (rx_q.size() !== 1) begin
         bad++;
         $display("FAIL after_rst_count: got %0d want %0d", rx_q.size(), 1);
      end
      total++;
      if (data_out !== 8'hC3) begin
         bad++;
         $display("FAIL after_rst_data: got %h want %h", data_out, 8'hC3);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_rd_en();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SEQ, default 100000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port rd_en, input, 1 bit: receiver enable; high allows a new frame to start.
REQ-006 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port data_out, output, 8 bits: last correctly received byte.
REQ-008 SHALL have port rd_done, output, 1 bit: one-cycle pulse on each valid frame.

Function
REQ-009 SHALL use local constant CLKS_PER_BIT = SEQ/BAUD_RATE (integer division; 10416 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (5208).
REQ-010 SHALL pass RX through a 2-flop synchronizer; all decisions use the synchronized value rx_s; X/unknown before the first drive is tolerated.
REQ-011 SHALL use an FSM with states IDLE, START, DATA, STOP, DONE, plus an internal bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-012 IDLE: when rd_en=1 and rx_s=0, SHALL clear the counter and go to START; when rd_en=0, SHALL ignore RX entirely.
REQ-013 START: at count HALF_BIT-1 SHALL re-check rx_s; if 0, clear the counter and go to DATA; if 1 (glitch), return to IDLE with no output change.
REQ-014 DATA: every CLKS_PER_BIT cycles (mid-bit) SHALL shift rx_s into an 8-bit shift register, LSB first; after bit index 7, go to STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; if 1, load data_out from the shift register and go to DONE; if 0 (framing error), discard the byte, leave data_out unchanged, and go to IDLE.
REQ-016 DONE: SHALL assert rd_done for exactly one clock, then go to IDLE; data_out becomes valid in the same cycle rd_done rises.
REQ-017 rd_done SHALL be 0 in every state except DONE.
REQ-018 data_out SHALL hold its value until the next valid frame; it SHALL never show partial bytes.
REQ-019 Dropping rd_en mid-frame SHALL NOT abort the frame; rd_en is sampled only in IDLE.
REQ-020 After DONE, a falling edge starting a new frame SHALL be detected immediately, supporting back-to-back frames whose stop bit is exactly one bit long.
REQ-021 rd_done latency SHALL be about 9.5 bit times plus 2-3 clocks (synchronizer) after the RX start edge.

Reset
REQ-022 When rst_n=0 at a clk edge: state=IDLE, counters=0, shift register=0, data_out=8'h00, rd_done=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no rd_done pulse; reception resumes on the next start edge after release.

Structure
REQ-024 A shared package SHALL hold the FSM state enum (IDLE, START, DATA, STOP, DONE) and the frame width constant (8).
REQ-025 One sub-module SHALL be used: sync_2ff (a 2-flop synchronizer with reset value 1); the rest stays in uart_rx.

Verification
REQ-026 Scenario: rd_en=1, send 0xA5 (LSB first, 10416-clock bits, stop=1) -> data_out=8'hA5 with a 1-clock rd_done pulse about 9.5 bit times after the start edge.
REQ-027 Scenario: five back-to-back random bytes (e.g. 0x3C, 0xFF, 0x00, 0x81, 0x5A) with no idle gap -> five rd_done pulses, data_out matching each byte in order.
REQ-028 Scenario: RX low pulse of 2000 clocks (< HALF_BIT) in IDLE -> FSM returns to IDLE, no rd_done, data_out unchanged.
REQ-029 Scenario: 0x55 frame with stop bit=0 -> no rd_done, data_out keeps its previous value; the next good frame 0x12 gives data_out=8'h12.
REQ-030 Scenario: rd_en=0 while 0x77 is sent -> no rd_done, data_out unchanged; rd_en=0 asserted mid-frame during 0x77 -> frame still completes, data_out=8'h77.
REQ-031 Scenario: rst_n=0 for one clock during DATA of a frame -> data_out=8'h00, rd_done=0, no pulse for that frame; the following frame 0xC3 is received correctly.
